// File: rtl/ber_checker.sv
// rtl/ber_checker.sv - symbol slicer with self-synchronising PRBS9 bit-error counter
// Decimates FIR samples at i_phase, slices on sign, locks a local PRBS9 and counts errors.
module ber_checker #(
  parameter int NB_DATA  = 13,
  parameter int OS_LOG   = 2,
  parameter int NB_CNT   = 32,
  parameter int WIN_LOG  = 7,
  parameter int LOCK_THR = 8
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_clear,
  input  logic                i_valid,
  input  logic [NB_DATA-1:0]  i_data,
  input  logic [OS_LOG-1:0]   i_phase,
  output logic                o_lock,
  output logic [NB_CNT-1:0]   o_bit_count,
  output logic [NB_CNT-1:0]   o_err_count,
  output logic                o_bit
);

  typedef enum logic {LOAD, CHECK} state_t;

  localparam logic [WIN_LOG:0] THR = (WIN_LOG+1)'(LOCK_THR);

  state_t              state;
  logic [OS_LOG-1:0]   ph;
  logic [3:0]          lc;
  logic [8:0]          r;
  logic [WIN_LOG-1:0]  win_cnt;
  logic [WIN_LOG-1:0]  win_err;

  logic                sym;
  logic                d;
  logic                e;
  logic                err;
  logic [WIN_LOG:0]    win_total;
  logic                unused_data;

  always_comb begin
    sym       = i_enable & i_valid & (ph == i_phase);
    d         = i_data[NB_DATA-1];
    e         = r[8] ^ r[4];
    err       = d ^ e;
    win_total = {1'b0, win_err} + (WIN_LOG+1)'(err);
  end

  assign unused_data = ^i_data[NB_DATA-2:0];

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      state       <= LOAD;
      o_lock      <= 1'b0;
      ph          <= '0;
      lc          <= '0;
      r           <= '0;
      win_cnt     <= '0;
      win_err     <= '0;
      o_bit       <= 1'b0;
      o_bit_count <= '0;
      o_err_count <= '0;
    end else begin
      if (i_enable && i_valid)
        ph <= ph + 1'b1;

      if (!i_enable) begin
        state   <= LOAD;
        o_lock  <= 1'b0;
        lc      <= '0;
        win_cnt <= '0;
        win_err <= '0;
      end else if (sym) begin
        o_bit <= d;
        if (state == LOAD) begin
          r <= {r[7:0], d};
          if (lc == 4'd8) begin
            state  <= CHECK;
            o_lock <= 1'b1;
            lc     <= '0;
          end else begin
            lc <= lc + 1'b1;
          end
        end else begin
          // Shift in the expected bit so a channel error never corrupts the generator
          r <= {r[7:0], e};
          if (&win_cnt) begin
            if (win_total > THR) begin
              state  <= LOAD;
              o_lock <= 1'b0;
            end
            win_cnt <= '0;
            win_err <= '0;
          end else begin
            win_cnt <= win_cnt + 1'b1;
            if (!(&win_err))
              win_err <= win_err + WIN_LOG'(err);
          end
        end
      end

      // Clear takes priority over a coincident counted symbol
      if (i_clear) begin
        o_bit_count <= '0;
        o_err_count <= '0;
      end else if (sym && state == CHECK) begin
        if (!(&o_bit_count))
          o_bit_count <= o_bit_count + 1'b1;
        if (err && !(&o_err_count))
          o_err_count <= o_err_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ber_checker.sv
// tb/tb_ber_checker.sv - self-checking bench for ber_checker
// Runs a 32-bit and a 4-bit counter build side by side against a queue-based reference.
module tb_ber_checker;

  logic        clock = 1'b0;
  logic        rst   = 1'b0;
  logic        en    = 1'b1;
  logic        clr   = 1'b0;
  logic        valid = 1'b0;
  logic [12:0] data  = '0;
  logic [1:0]  phase = 2'd0;

  logic        lock_a, bit_a, lock_b, bit_b;
  logic [31:0] bc_a, ec_a;
  logic [3:0]  bc_b, ec_b;

  always #5 clock = ~clock;

  ber_checker dut_a (
    .clock(clock), .i_reset(rst), .i_enable(en), .i_clear(clr), .i_valid(valid),
    .i_data(data), .i_phase(phase), .o_lock(lock_a), .o_bit_count(bc_a),
    .o_err_count(ec_a), .o_bit(bit_a)
  );

  ber_checker #(.NB_CNT(4)) dut_b (
    .clock(clock), .i_reset(rst), .i_enable(en), .i_clear(clr), .i_valid(valid),
    .i_data(data), .i_phase(phase), .o_lock(lock_b), .o_bit_count(bc_b),
    .o_err_count(ec_b), .o_bit(bit_b)
  );

  int n_vec  = 0;
  int n_fail = 0;

  // Reference state: history of the last nine reference bits, oldest first
  int     m_ph, m_lc, m_wc, m_we;
  bit     m_locked, m_bit;
  bit     hist[$];
  longint m_bc, m_ec, m_bc4, m_ec4;

  // Stimulus PRBS9 source, s[n] = s[n-9] ^ s[n-5]
  bit     src[$];

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      if (n_fail < 40)
        $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_lc = 0; m_wc = 0; m_we = 0;
    m_locked = 0; m_bit = 0;
    m_bc = 0; m_ec = 0; m_bc4 = 0; m_ec4 = 0;
    hist.delete();
    repeat (9) hist.push_back(1'b0);
  endtask

  task automatic model_step();
    bit s, dd, ee, er, was_locked;
    if (!rst) begin
      model_reset();
      return;
    end
    dd = data[12];
    s  = en && valid && (m_ph == int'(phase));
    was_locked = m_locked;
    er = 1'b0;
    if (en && valid) m_ph = (m_ph + 1) % 4;
    if (!en) begin
      m_locked = 0; m_lc = 0; m_wc = 0; m_we = 0;
    end else if (s) begin
      m_bit = dd;
      if (!m_locked) begin
        hist.push_back(dd);
        void'(hist.pop_front());
        m_lc++;
        if (m_lc == 9) begin m_locked = 1; m_lc = 0; end
      end else begin
        ee = hist[0] ^ hist[4];
        er = (dd != ee);
        hist.push_back(ee);
        void'(hist.pop_front());
        if (m_wc == 127) begin
          if (m_we + int'(er) > 8) m_locked = 0;
          m_wc = 0; m_we = 0;
        end else begin
          m_wc++;
          m_we = int'(sat(m_we + int'(er), 127));
        end
      end
    end
    if (clr) begin
      m_bc = 0; m_ec = 0; m_bc4 = 0; m_ec4 = 0;
    end else if (s && was_locked) begin
      m_bc  = sat(m_bc + 1, 64'hFFFF_FFFF);
      m_ec  = sat(m_ec + er, 64'hFFFF_FFFF);
      m_bc4 = sat(m_bc4 + 1, 15);
      m_ec4 = sat(m_ec4 + er, 15);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_step();
    #1;
    check("lock",     lock_a, m_locked);
    check("bit",      bit_a,  m_bit);
    check("bit_cnt",  bc_a,   m_bc);
    check("err_cnt",  ec_a,   m_ec);
    check("lock4",    lock_b, m_locked);
    check("bit_cnt4", bc_b,   m_bc4);
    check("err_cnt4", ec_b,   m_ec4);
  endtask

  function automatic bit prbs_next();
    bit b;
    b = src[0] ^ src[4];
    src.push_back(b);
    void'(src.pop_front());
    return b;
  endfunction

  // One symbol of four samples; zero_others leaves only sample 2 non-zero
  task automatic send_sym(input bit b, input int gap, input bit clr_at_sym, input bit zero_others);
    for (int k = 0; k < 4; k++) begin
      valid = 1'b1;
      data  = (zero_others && k != 2) ? 13'd0 : (b ? 13'h1C18 : 13'd1000);
      clr   = clr_at_sym && (k == int'(phase));
      step();
      valid = 1'b0;
      clr   = 1'b0;
      repeat (gap - 1) step();
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  typedef struct {
    logic        rst, en, clr, valid;
    logic [12:0] data;
    logic [1:0]  phase;
    logic        lock, bit_o;
    int          bc, ec;
  } vec_t;

  vec_t tbl[9];
  bit   saw_unlock;
  bit   b;
  longint saved_bc, saved_ec;

  initial begin
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 13'($urandom), 2'd0, 1'b0, 1'b0, 0, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 13'($urandom), 2'd0, 1'b0, 1'b0, 0, 0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 13'h1FFB,     2'd0, 1'b0, 1'b0, 0, 0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 13'h1FFB,     2'd1, 1'b0, 1'b0, 0, 0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 13'h1FFB,     2'd1, 1'b0, 1'b1, 0, 0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 13'd100,      2'd1, 1'b0, 1'b1, 0, 0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 13'd0,        2'd3, 1'b0, 1'b0, 0, 0};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 13'h1FFF,     2'd0, 1'b0, 1'b1, 0, 0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 13'd5,        2'd1, 1'b0, 1'b1, 0, 0};

    model_reset();
    src.delete();
    foreach (tbl[i]) src.push_back(1'b0);
    src[0] = 1'b1;
    src[6] = 1'b1;

    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; clr = tbl[i].clr; valid = tbl[i].valid;
      data = tbl[i].data; phase = tbl[i].phase;
      step();
      check("tbl_lock", lock_a, tbl[i].lock);
      check("tbl_bit",  bit_a,  tbl[i].bit_o);
      check("tbl_bc",   bc_a,   tbl[i].bc);
      check("tbl_ec",   ec_a,   tbl[i].ec);
    end
    valid = 1'b0; en = 1'b1;

    // Clean lock with sparse strobes
    pulse_reset();
    phase = 2'd2;
    for (int i = 0; i < 8; i++) send_sym(prbs_next(), 8, 1'b0, 1'b0);
    check("unlocked_after_8", lock_a, 0);
    send_sym(prbs_next(), 8, 1'b0, 1'b0);
    check("locked_after_9", lock_a, 1);

    for (int i = 0; i < 1000; i++) send_sym(prbs_next(), 1, 1'b0, 1'b0);
    check("clean_bc", bc_a, 1000);
    check("clean_ec", ec_a, 0);
    check("sat_bc4",  bc_b, 15);

    // Single sign error on one symbol
    for (int i = 0; i < 300; i++) begin
      b = prbs_next();
      send_sym(b ^ (i == 200), 1, 1'b0, 1'b0);
    end
    check("single_ec",   ec_a,   1);
    check("single_bc",   bc_a,   1300);
    check("single_lock", lock_a, 1);

    // Inverted stream forces loss of lock
    saw_unlock = 1'b0;
    for (int i = 0; i < 128; i++) begin
      send_sym(~prbs_next(), 1, 1'b0, 1'b0);
      if (!lock_a) saw_unlock = 1'b1;
    end
    check("lock_lost", saw_unlock, 1);
    check("sat_ec4",   ec_b, 15);

    for (int i = 0; i < 300; i++) send_sym(prbs_next(), 1, 1'b0, 1'b0);
    check("relock", lock_a, 1);

    // Clear coinciding with an erroneous symbol
    send_sym(~prbs_next(), 1, 1'b1, 1'b0);
    check("clr_bc", bc_a, 0);
    check("clr_ec", ec_a, 0);
    for (int i = 0; i < 20; i++) send_sym(prbs_next(), 1, 1'b0, 1'b0);

    // Disable for 50 cycles mid-CHECK
    saved_bc = bc_a;
    saved_ec = ec_a;
    en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      valid = 1'($urandom);
      data  = 13'($urandom);
      step();
    end
    valid = 1'b0;
    check("dis_lock", lock_a, 0);
    check("dis_bc",   bc_a,   saved_bc);
    check("dis_ec",   ec_a,   saved_ec);
    en = 1'b1;
    for (int i = 0; i < 9; i++) send_sym(prbs_next(), 2, 1'b0, 1'b0);
    check("reen_lock", lock_a, 1);

    // Only sample 2 carries the symbol
    pulse_reset();
    phase = 2'd2;
    for (int i = 0; i < 150; i++) send_sym(prbs_next(), 1, 1'b0, 1'b1);
    check("ph2_lock", lock_a, 1);
    check("ph2_ec",   ec_a,   0);
    pulse_reset();
    phase = 2'd0;
    for (int i = 0; i < 150; i++) send_sym(prbs_next(), 1, 1'b0, 1'b1);
    check("ph0_bit", bit_a, 0);
    check("ph0_ec",  ec_a,  0);

    // Random traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 299) != 0);
      en    = ($urandom_range(0, 59) != 0);
      clr   = ($urandom_range(0, 149) == 0);
      valid = 1'($urandom);
      data  = ($urandom_range(0, 3) == 0) ? 13'd0 : 13'($urandom);
      if ($urandom_range(0, 99) == 0) phase = 2'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
